xsleena_sdram_arb: RTL and testbench
====================================

# xsleena_sdram_arb

Five-port SDRAM read responder serving the XSleena core's ROM fetch clients (main CPU, sub CPU, OBJ, BACK1, BACK2) on the `sdr_*_addr/req/rdy/dout` toggle handshake. It arbitrates pending requests round-robin and forwards one read at a time to the single-port SDRAM controller. Each completed word is returned to its client with an `rdy` toggle. It sits in the `SDR_CLK` domain between the core and the SDRAM controller.

## Interface
- `TIMEOUT`, default 255: WAIT-state cycles without `ctl_valid` before forced completion; 8-bit counter.
- `clk` in 1: SDRAM-domain clock (`SDR_CLK`); all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `sdr_N_addr` in 25: word address from client N. N ∈ {mcpu=0, scpu=1, obj=2, bg1=3, bg2=4}.
- `sdr_N_req` in 1: request toggle from client N.
- `sdr_N_rdy` out 1: completion toggle to client N.
- `sdr_N_dout` out 16: last word returned to client N.
- `ctl_addr` out 25: address to the SDRAM controller.
- `ctl_rd` out 1: one-cycle read strobe.
- `ctl_ready` in 1: controller can accept a strobe this cycle.
- `ctl_valid` in 1: one-cycle strobe; `ctl_dout` holds read data.
- `ctl_dout` in 16: read data.
- `timeout_err` out 1: sticky flag, set on any forced completion.

## Operation
- The protocol is toggle-based. Port N is pending when `sdr_N_req != sdr_N_rdy`.
  - A client toggles `req` once per access.
  - The client holds `addr` stable until `rdy` equals `req`.
  - If `req` toggles twice while pending, the two toggles cancel. This is legal only before grant; after grant the access completes regardless.
- Round-robin pointer `ptr` (0..4):
  - Grant goes to the first pending port, searching `ptr, ptr+1, …` mod 5.
  - After completion, `ptr` = granted port + 1, wrapping from 4 to 0.
- FSM states:
  - **IDLE**: if any port is pending and `ctl_ready`=1:
    - latch `gnt`;
    - `ctl_addr` ← `sdr_gnt_addr`;
    - go to ISSUE.
    - Otherwise stay in IDLE.
  - **ISSUE**: `ctl_rd`=1 for exactly this cycle, then go to WAIT. Clear the timeout counter.
  - **WAIT**: on `ctl_valid`=1:
    - `sdr_gnt_dout` ← `ctl_dout`;
    - toggle `sdr_gnt_rdy`;
    - update `ptr`;
    - go to IDLE.
    - Otherwise, if the counter equals `TIMEOUT`: `dout` ← 16'hFFFF, toggle `rdy`, set `timeout_err`, update `ptr`, go to IDLE.
    - Otherwise increment the counter.
- `ctl_valid` outside WAIT is ignored and leaves no state change. This covers stale responses after a reset or a timeout.
- The `dout` of non-granted ports is never modified.
- Address is passed through unmodified. Bank and row mapping belongs to the controller.

## Timing
- Reset values:
  - all `sdr_N_rdy`=0, all `sdr_N_dout`=16'h0000;
  - `ctl_rd`=0, `ctl_addr`=0, `timeout_err`=0;
  - `ptr`=0, state IDLE, counter 0.
- Reset mid-operation aborts the access: no `rdy` toggle, no `dout` write.
  - A client whose `req` is 1 after reset is pending in the first post-reset cycle.
- Let c be the first cycle `req` is toggled and visible, with the arbiter IDLE and `ctl_ready`=1:
  - the grant latches at the edge ending c;
  - `ctl_rd`=1 during c+1;
  - WAIT starts at c+2.
- `ctl_valid` in cycle v produces the `rdy` toggle and `dout` update visible in cycle v+1; the state is IDLE in v+1.
  - Back-to-back: the next `ctl_rd` is in v+2 at the earliest.
  - Minimum req→rdy latency is (controller latency) + 3 cycles.
- Timeout completion is visible `TIMEOUT`+1 cycles after WAIT entry.
- At most one outstanding controller read. `ctl_rd` is never asserted in WAIT.
- Starvation bound: a pending port is granted within 4 completions of other ports.

## Test plan
- Single access: reset, then mcpu toggles `req` 0→1 with addr 25'h0001234. Controller returns 16'hBEEF 4 cycles after `ctl_rd`. Required: `ctl_addr`=25'h0001234, exactly one `ctl_rd` pulse; `sdr_mcpu_rdy`=1 and `dout`=16'hBEEF one cycle after `ctl_valid`; other ports unchanged.
- Round-robin: all 5 ports toggle in the same cycle with `ptr`=0. Required grant order 0,1,2,3,4. Then, with ports 4 and 1 re-pending (`ptr`=0), port 1 is granted before port 4.
- Backpressure: `ctl_ready`=0 for 10 cycles with obj pending. Required: no `ctl_rd` while low; `ctl_rd` exactly one cycle after `ctl_ready` rises.
- Timeout: `TIMEOUT`=15, bg2 pending, controller never answers. Required: `sdr_bg2_rdy` toggles with `dout`=16'hFFFF 16 cycles after WAIT entry; `timeout_err`=1. A late `ctl_valid` afterwards changes nothing.
- Reset mid-WAIT: scpu granted, `RST` pulsed for 1 cycle, then `ctl_valid` arrives. Required: `scpu_rdy`=0, `dout`=0, state IDLE. scpu (`req`=1) is re-granted and completes normally.
- Stale response: `ctl_valid` pulsed while IDLE with no pending ports. Required: no `rdy` or `dout` change on any port.

Source files
------------

// File: rtl/xsleena_sdram_arb.sv
// rtl/xsleena_sdram_arb.sv - five-port round-robin SDRAM read responder on a toggle handshake
module xsleena_sdram_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [24:0] sdr_mcpu_addr,
    input  logic        sdr_mcpu_req,
    output logic        sdr_mcpu_rdy,
    output logic [15:0] sdr_mcpu_dout,
    input  logic [24:0] sdr_scpu_addr,
    input  logic        sdr_scpu_req,
    output logic        sdr_scpu_rdy,
    output logic [15:0] sdr_scpu_dout,
    input  logic [24:0] sdr_obj_addr,
    input  logic        sdr_obj_req,
    output logic        sdr_obj_rdy,
    output logic [15:0] sdr_obj_dout,
    input  logic [24:0] sdr_bg1_addr,
    input  logic        sdr_bg1_req,
    output logic        sdr_bg1_rdy,
    output logic [15:0] sdr_bg1_dout,
    input  logic [24:0] sdr_bg2_addr,
    input  logic        sdr_bg2_req,
    output logic        sdr_bg2_rdy,
    output logic [15:0] sdr_bg2_dout,
    output logic [24:0] ctl_addr,
    output logic        ctl_rd,
    input  logic        ctl_ready,
    input  logic        ctl_valid,
    input  logic [15:0] ctl_dout,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [24:0] addr_v [5];
    logic [4:0]  req_v;
    logic [4:0]  rdy_r;
    logic [15:0] dout_r [5];
    logic [4:0]  pending;
    logic [2:0]  ptr, gnt, pick, ptr_nxt;
    logic        any_pend;
    logic [3:0]  rr_sum;
    logic [2:0]  rr_idx;
    logic [7:0]  cnt;
    logic        expired;

    assign addr_v[0] = sdr_mcpu_addr;
    assign addr_v[1] = sdr_scpu_addr;
    assign addr_v[2] = sdr_obj_addr;
    assign addr_v[3] = sdr_bg1_addr;
    assign addr_v[4] = sdr_bg2_addr;
    assign req_v     = {sdr_bg2_req, sdr_bg1_req, sdr_obj_req, sdr_scpu_req, sdr_mcpu_req};

    assign sdr_mcpu_rdy  = rdy_r[0];
    assign sdr_scpu_rdy  = rdy_r[1];
    assign sdr_obj_rdy   = rdy_r[2];
    assign sdr_bg1_rdy   = rdy_r[3];
    assign sdr_bg2_rdy   = rdy_r[4];
    assign sdr_mcpu_dout = dout_r[0];
    assign sdr_scpu_dout = dout_r[1];
    assign sdr_obj_dout  = dout_r[2];
    assign sdr_bg1_dout  = dout_r[3];
    assign sdr_bg2_dout  = dout_r[4];

    assign pending = req_v ^ rdy_r;
    assign ctl_rd  = (state == S_ISSUE);
    assign expired = (cnt == 8'(TIMEOUT));
    assign ptr_nxt = (gnt == 3'd4) ? 3'd0 : gnt + 3'd1;

    // Scan from the far end back to ptr so the nearest pending port wins.
    always_comb begin
        pick     = ptr;
        any_pend = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int k = 4; k >= 0; k--) begin
            rr_sum = {1'b0, ptr} + 4'(k);
            rr_idx = (rr_sum >= 4'd5) ? 3'(rr_sum - 4'd5) : rr_sum[2:0];
            if (pending[rr_idx]) begin
                pick     = rr_idx;
                any_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_pend && ctl_ready) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (ctl_valid || expired) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rdy_r       <= '0;
            ctl_addr    <= '0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            for (int i = 0; i < 5; i++) dout_r[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_pend && ctl_ready) begin
                        gnt      <= pick;
                        ctl_addr <= addr_v[pick];
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (ctl_valid) begin
                        dout_r[gnt] <= ctl_dout;
                        rdy_r[gnt]  <= ~rdy_r[gnt];
                        ptr         <= ptr_nxt;
                    end else if (expired) begin
                        // Forced completion so a dead controller cannot hang the client.
                        dout_r[gnt] <= 16'hFFFF;
                        rdy_r[gnt]  <= ~rdy_r[gnt];
                        timeout_err <= 1'b1;
                        ptr         <= ptr_nxt;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xsleena_sdram_arb.sv
// tb/tb_xsleena_sdram_arb.sv - self-checking bench for xsleena_sdram_arb
module tb_xsleena_sdram_arb;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [24:0] addr [5];
    logic [4:0]  req = '0;
    wire         rdy [5];
    wire  [15:0] dout [5];
    wire  [24:0] ctl_addr;
    wire         ctl_rd;
    logic        ctl_ready = 1'b1;
    logic        ctl_valid = 1'b0;
    logic [15:0] ctl_dout = '0;
    wire         timeout_err;

    int tests = 0;
    int fails = 0;

    // Reference model: what each client should see, plus the round-robin pointer.
    bit [4:0]    m_rdy;
    logic [15:0] m_dout [5];
    int          mptr;
    bit          m_terr;

    xsleena_sdram_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .RST(RST),
        .sdr_mcpu_addr(addr[0]), .sdr_mcpu_req(req[0]), .sdr_mcpu_rdy(rdy[0]), .sdr_mcpu_dout(dout[0]),
        .sdr_scpu_addr(addr[1]), .sdr_scpu_req(req[1]), .sdr_scpu_rdy(rdy[1]), .sdr_scpu_dout(dout[1]),
        .sdr_obj_addr(addr[2]),  .sdr_obj_req(req[2]),  .sdr_obj_rdy(rdy[2]),  .sdr_obj_dout(dout[2]),
        .sdr_bg1_addr(addr[3]),  .sdr_bg1_req(req[3]),  .sdr_bg1_rdy(rdy[3]),  .sdr_bg1_dout(dout[3]),
        .sdr_bg2_addr(addr[4]),  .sdr_bg2_req(req[4]),  .sdr_bg2_rdy(rdy[4]),  .sdr_bg2_dout(dout[4]),
        .ctl_addr(ctl_addr), .ctl_rd(ctl_rd), .ctl_ready(ctl_ready),
        .ctl_valid(ctl_valid), .ctl_dout(ctl_dout), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < 5; k++) begin
            int p = (mptr + k) % 5;
            if (req[p] != m_rdy[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rdy  = '0;
        mptr   = 0;
        m_terr = 1'b0;
        for (int p = 0; p < 5; p++) m_dout[p] = '0;
    endtask

    task automatic complete(input int g, input logic [15:0] data);
        m_rdy[g]  = ~m_rdy[g];
        m_dout[g] = data;
        mptr      = (g + 1) % 5;
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("%s_rdy%0d", tag, p), 32'(rdy[p]), 32'(m_rdy[p]));
            chk($sformatf("%s_dout%0d", tag, p), 32'(dout[p]), 32'(m_dout[p]));
        end
        chk({tag, "_terr"}, 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic reset_dut();
        RST       = 1'b1;
        req       = '0;
        ctl_valid = 1'b0;
        ctl_ready = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        model_reset();
    endtask

    task automatic toggle(input int p, input logic [24:0] a);
        addr[p] = a;
        req[p]  = ~req[p];
    endtask

    task automatic wait_rd(input string tag, output bit ok);
        int n = 0;
        while (ctl_rd !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        ok = (n < 64);
        chk({tag, "_rd_seen"}, 32'(ok), 32'd1);
    endtask

    // One full access: expect the model's grant, answer after lat cycles.
    task automatic serve(input int lat, input logic [15:0] data, input string tag,
                         output logic [24:0] seen);
        bit ok;
        int g;
        g    = pick();
        seen = 'x;
        wait_rd(tag, ok);
        if (!ok || g < 0) return;
        seen = ctl_addr;
        chk({tag, "_addr"}, 32'(ctl_addr), 32'(addr[g]));
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, "_no_rd_in_wait"}, 32'(ctl_rd), 32'd0);
        end
        ctl_valid = 1'b1;
        ctl_dout  = data;
        tick();
        ctl_valid = 1'b0;
        complete(g, data);
        check_all(tag);
    endtask

    initial begin
        logic [24:0] seen;
        bit          ok;

        for (int p = 0; p < 5; p++) addr[p] = '0;
        model_reset();

        reset_dut();
        chk("reset_ctl_rd", 32'(ctl_rd), 32'd0);
        chk("reset_ctl_addr", 32'(ctl_addr), 32'd0);
        check_all("reset");

        toggle(0, 25'h0001234);
        serve(4, 16'hBEEF, "single", seen);
        chk("single_seen_addr", 32'(seen), 32'h0001234);
        chk("single_dout", 32'(dout[0]), 32'h0000BEEF);
        chk("single_rdy", 32'(rdy[0]), 32'd1);

        reset_dut();
        for (int p = 0; p < 5; p++) toggle(p, {3'(p), 22'($urandom)});
        for (int i = 0; i < 5; i++) begin
            serve(int'($urandom_range(1, 6)), 16'($urandom), "rr", seen);
            chk($sformatf("rr_order%0d", i), 32'(seen), 32'(addr[i]));
        end
        toggle(4, 25'h1C00044);
        toggle(1, 25'h0400011);
        serve(2, 16'h1111, "rr41_a", seen);
        chk("rr41_first", 32'(seen), 32'h0400011);
        serve(3, 16'h4444, "rr41_b", seen);
        chk("rr41_second", 32'(seen), 32'h1C00044);

        ctl_ready = 1'b0;
        toggle(2, 25'h0802222);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_no_rd", 32'(ctl_rd), 32'd0);
        end
        ctl_ready = 1'b1;
        tick();
        chk("bp_rd_after_ready", 32'(ctl_rd), 32'd1);
        serve(5, 16'h2222, "bp", seen);

        tick();
        ctl_valid = 1'b1;
        ctl_dout  = 16'h5555;
        tick();
        ctl_valid = 1'b0;
        tick();
        check_all("stale");

        reset_dut();
        toggle(1, 25'h0ABCDEF);
        wait_rd("rstw", ok);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST       = 1'b0;
        ctl_valid = 1'b1;
        ctl_dout  = 16'hDEAD;
        model_reset();
        tick();
        ctl_valid = 1'b0;
        chk("rstw_rdy", 32'(rdy[1]), 32'd0);
        chk("rstw_dout", 32'(dout[1]), 32'd0);
        chk("rstw_regrant", 32'(ctl_rd), 32'd1);
        serve(3, 16'h7777, "rstw_redo", seen);
        chk("rstw_redo_dout", 32'(dout[1]), 32'h00007777);

        reset_dut();
        toggle(4, 25'h1234567);
        wait_rd("to", ok);
        chk("to_addr", 32'(ctl_addr), 32'h1234567);
        for (int i = 1; i <= TO + 2; i++) begin
            tick();
            if (i == TO + 1) chk("to_not_early", 32'(rdy[4]), 32'd0);
        end
        complete(4, 16'hFFFF);
        m_terr = 1'b1;
        check_all("timeout");
        chk("to_dout", 32'(dout[4]), 32'h0000FFFF);
        chk("to_err", 32'(timeout_err), 32'd1);
        ctl_valid = 1'b1;
        ctl_dout  = 16'h1234;
        tick();
        ctl_valid = 1'b0;
        tick();
        check_all("late");

        reset_dut();
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 5; p++)
                if (req[p] == m_rdy[p] && $urandom_range(0, 1) == 1)
                    toggle(p, {3'(p), 22'($urandom)});
            if (pick() < 0) continue;
            if ($urandom_range(0, 3) == 0) begin
                ctl_ready = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                ctl_ready = 1'b1;
            end
            serve(int'($urandom_range(1, 12)), 16'($urandom), $sformatf("rand%0d", r), seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
